// File: rtl/alu_exec_unit.sv
// alu_exec_unit: valid/ready ALU (add/sub/and/or/slt) with a registered result stage.
// Optional macro ALU_MUL_EN adds code 110 as an iterative one-bit-per-cycle multiply.
`default_nettype none

module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [2:0]       alu_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_SUB = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SLT = 3'b101;
`ifdef ALU_MUL_EN
   localparam logic [2:0] OP_MUL = 3'b110;
`endif

   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             illegal_q, illegal_d;
   logic             out_valid_q, out_valid_d;

   logic [WIDTH-1:0] alu_res;
   logic             alu_ill;
   logic             is_mul;
   logic             idle;
   logic             accept;

`ifdef ALU_MUL_EN
   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_MUL  = 1'b1
   } state_t;

   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(WIDTH);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0] acc_step;

   assign idle = (state_q == S_IDLE);
`else
   assign idle = 1'b1;
`endif

   always_comb begin : decode
      alu_res = '0;
      alu_ill = 1'b0;
      is_mul  = 1'b0;
      case (alu_control)
         OP_ADD:  alu_res = a + b;
         OP_SUB:  alu_res = a - b;
         OP_AND:  alu_res = a & b;
         OP_OR:   alu_res = a | b;
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
`ifdef ALU_MUL_EN
         OP_MUL:  is_mul  = 1'b1;
`endif
         default: alu_ill = 1'b1;
      endcase
   end

   // Ready only when the output slot is free or being drained this same edge.
   assign in_ready = reset_n & idle & (~out_valid_q | out_ready);
   assign accept   = in_valid & in_ready;

   always_comb begin : next_state
      out_valid_d = out_valid_q;
      result_d    = result_q;
      zero_d      = zero_q;
      illegal_d   = illegal_q;
`ifdef ALU_MUL_EN
      state_d     = state_q;
      cnt_d       = cnt_q;
      mcand_d     = mcand_q;
      mplier_d    = mplier_q;
      acc_d       = acc_q;
      acc_step    = acc_q + (mplier_q[0] ? mcand_q : '0);
`endif

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      if (accept && !is_mul) begin
         out_valid_d = 1'b1;
         result_d    = alu_res;
         zero_d      = (alu_res == '0);
         illegal_d   = alu_ill;
      end

`ifdef ALU_MUL_EN
      if (accept && is_mul) begin
         state_d  = S_MUL;
         cnt_d    = '0;
         mcand_d  = a;
         mplier_d = b;
         acc_d    = '0;
      end

      // One multiplier bit per edge; operands are private copies so the inputs may change.
      if (state_q == S_MUL) begin
         acc_d    = acc_step;
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         cnt_d    = cnt_q + CNT_W'(1);
         if (cnt_d == CNT_DONE) begin
            state_d     = S_IDLE;
            cnt_d       = '0;
            out_valid_d = 1'b1;
            result_d    = acc_step;
            zero_d      = (acc_step == '0);
            illegal_d   = 1'b0;
         end
      end
`endif
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         illegal_q   <= 1'b0;
`ifdef ALU_MUL_EN
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
         illegal_q   <= illegal_d;
`ifdef ALU_MUL_EN
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
`endif
      end
   end

   assign out_valid = out_valid_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign illegal   = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (WIDTH=32), with or without ALU_MUL_EN.
`default_nettype none

module tb_alu_exec_unit;

   logic        clk;
   logic        reset_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic [2:0]  alu_control;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        illegal;

   int checks = 0;
   int errors = 0;

   alu_exec_unit #(.WIDTH(32)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .a           (a),
      .b           (b),
      .alu_control (alu_control),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .illegal     (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Present one operation, let it be taken on the next edge, then withdraw it.
   task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic [2:0] op);
      a = av; b = bv; alu_control = op; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic test_reset();
      #2;
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got %b exp 0", in_ready); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL rst_result got %h exp 0", result); end
      checks++; if (zero !== 1'b0) begin errors++; $display("FAIL rst_zero got %b exp 0", zero); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b exp 0", illegal); end
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got %b exp 1", in_ready); end
   endtask

   task automatic test_add();
      out_ready = 1'b1;
      issue(32'd5, 32'd7, 3'b000);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_valid got %b exp 1", out_valid); end
      checks++; if (result !== 32'd12) begin errors++; $display("FAIL add_result got %0d exp 12", result); end
      checks++; if (zero !== 1'b0) begin errors++; $display("FAIL add_zero got %b exp 0", zero); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL add_illegal got %b exp 0", illegal); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL add_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_back_to_back();
      out_ready = 1'b1;
      a = 32'd9; b = 32'd9; alu_control = 3'b001; in_valid = 1'b1;
      @(posedge clk); #1;
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL sub_result got %h exp 0", result); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL sub_zero got %b exp 1", zero); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b exp 1", in_ready); end
      a = 32'hFFFF_FFFF; b = 32'd1; alu_control = 3'b101;
      @(posedge clk); #1;
      in_valid = 1'b0;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL slt_valid got %b exp 1", out_valid); end
      checks++; if (result !== 32'd1) begin errors++; $display("FAIL slt_result got %h exp 1", result); end
      checks++; if (zero !== 1'b0) begin errors++; $display("FAIL slt_zero got %b exp 0", zero); end
      issue(32'd1, 32'hFFFF_FFFF, 3'b101);
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL slt_rev_result got %h exp 0", result); end
      issue(32'd3, 32'd5, 3'b001);
      checks++; if (result !== 32'hFFFF_FFFE) begin errors++; $display("FAIL sub_wrap got %h exp fffffffe", result); end
      issue(32'hFFFF_FFFF, 32'd2, 3'b000);
      checks++; if (result !== 32'd1) begin errors++; $display("FAIL add_wrap got %h exp 1", result); end
      @(posedge clk); #1;
   endtask

   task automatic test_hold();
      out_ready = 1'b0;
      issue(32'hF0, 32'h0F, 3'b011);
      a = 32'h1; b = 32'h2; alu_control = 3'b000; in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid[%0d] got %b exp 1", i, out_valid); end
         checks++; if (result !== 32'hFF) begin errors++; $display("FAIL hold_result[%0d] got %h exp ff", i, result); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready[%0d] got %b exp 0", i, in_ready); end
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      out_ready = 1'b1; #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_ready got %b exp 1", in_ready); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_drain got %b exp 0", out_valid); end
   endtask

   task automatic test_illegal();
      out_ready = 1'b1;
      issue(32'h1234, 32'h5678, 3'b100);
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL ill100_result got %h exp 0", result); end
      checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill100_flag got %b exp 1", illegal); end
      checks++; if (zero !== 1'b1) begin errors++; $display("FAIL ill100_zero got %b exp 1", zero); end
      issue(32'hFF, 32'h0F, 3'b010);
      checks++; if (result !== 32'h0F) begin errors++; $display("FAIL and_result got %h exp 0f", result); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL and_illegal got %b exp 0", illegal); end
      issue(32'd1, 32'd1, 3'b111);
      checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL ill111_flag got %b exp 1", illegal); end
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL ill111_result got %h exp 0", result); end
      @(posedge clk); #1;
   endtask

   task automatic test_mul();
`ifdef ALU_MUL_EN
      int  n;
      bit  ready_seen;
      out_ready = 1'b1;
      a = 32'd1234; b = 32'd5678; alu_control = 3'b110; in_valid = 1'b1;
      @(posedge clk); #1;
      n = 1;
      ready_seen = 1'b0;
      a = 32'hDEAD_BEEF; b = 32'h0000_1234; alu_control = 3'b000;
      while (out_valid !== 1'b1 && n < 40) begin
         if (in_ready !== 1'b0) ready_seen = 1'b1;
         @(posedge clk); #1;
         n++;
      end
      in_valid = 1'b0;
      checks++; if (ready_seen !== 1'b0) begin errors++; $display("FAIL mul_in_ready_busy got 1 exp 0"); end
      checks++; if (n !== 33) begin errors++; $display("FAIL mul_latency got %0d exp 33", n); end
      checks++; if (result !== 32'd7006652) begin errors++; $display("FAIL mul_result got %0d exp 7006652", result); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("FAIL mul_illegal got %b exp 0", illegal); end
      @(posedge clk); #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mul_drain got %b exp 0", out_valid); end
`else
      out_ready = 1'b1;
      issue(32'd1234, 32'd5678, 3'b110);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL mul_off_valid got %b exp 1", out_valid); end
      checks++; if (illegal !== 1'b1) begin errors++; $display("FAIL mul_off_illegal got %b exp 1", illegal); end
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL mul_off_result got %h exp 0", result); end
      @(posedge clk); #1;
`endif
   endtask

   task automatic test_reset_mid_op();
      bit valid_seen;
      out_ready = 1'b1;
`ifdef ALU_MUL_EN
      issue(32'd1234, 32'd5678, 3'b110);
      repeat (9) @(posedge clk);
`else
      out_ready = 1'b0;
      issue(32'hF0, 32'h0F, 3'b011);
      out_ready = 1'b1;
`endif
      #2 reset_n = 1'b0;
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got %b exp 0", in_ready); end
      checks++; if (result !== 32'd0) begin errors++; $display("FAIL midrst_result got %h exp 0", result); end
      @(negedge clk); reset_n = 1'b1;
      @(posedge clk); #1;
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_ready got %b exp 1", in_ready); end
      valid_seen = 1'b0;
      repeat (40) begin
         if (out_valid !== 1'b0) valid_seen = 1'b1;
         @(posedge clk); #1;
      end
      checks++; if (valid_seen !== 1'b0) begin errors++; $display("FAIL midrst_no_output got 1 exp 0"); end
   endtask

   initial begin
      reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      a = '0; b = '0; alu_control = 3'b000;
      test_reset();
      test_add();
      test_back_to_back();
      test_hold();
      test_illegal();
      test_mul();
      test_reset_mid_op();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
